// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: elastic pipeline that counts leading or trailing zeros and normalises the vector.
// Parameters:
//   WIDTH      input vector width (2..64)
//   STAGES     number of register stages (1..3)
//   CNT_WIDTH  derived count width, $clog2(WIDTH)
// Ports:
//   clk_i    clock, all state on the rising edge
//   rst_i    asynchronous active-high reset
//   valid_i  upstream transaction valid
//   ready_o  a transaction can be accepted this cycle
//   data_i   vector to count
//   mode_i   0 = trailing zeros / shift right, 1 = leading zeros / shift left
//   valid_o  result valid
//   ready_i  downstream accepts the result
//   cnt_o    zero count (WIDTH-1 for all-zero data)
//   empty_o  data was all zeros
//   norm_o   normalised data
module lzc_norm_pipe #(
    parameter int WIDTH = 32,
    parameter int STAGES = 2,
    localparam int CNT_WIDTH = $clog2(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 mode_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o,
    output logic [WIDTH-1:0]     norm_o
);
    // Later iterations overwrite earlier ones, so the scan order picks the
    // highest set bit in mode 1 and the lowest set bit in mode 0.
    function automatic logic [CNT_WIDTH-1:0] zcount(input logic [WIDTH-1:0] d, input logic m);
        logic [CNT_WIDTH-1:0] c;
        c = CNT_WIDTH'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (m && d[i]) c = CNT_WIDTH'(WIDTH - 1 - i);
            if (!m && d[WIDTH-1-i]) c = CNT_WIDTH'(WIDTH - 1 - i);
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] normalise(input logic [WIDTH-1:0] d, input logic m,
                                                   input logic [CNT_WIDTH-1:0] c);
        return m ? d << c : d >> c;
    endfunction

    logic                 v1, v2, v3;
    logic                 en1, en2, en3;
    logic [WIDTH-1:0]     d1, n1, n2, n3;
    logic                 m1, e1, e2, e3;
    logic [CNT_WIDTH-1:0] c1, c2, c3;
    logic [CNT_WIDTH-1:0] in_cnt;

    assign in_cnt = zcount(data_i, mode_i);

    // A stage loads when it is empty or its content moves on this cycle.
    assign en3 = !v3 || ready_i;
    assign en2 = !v2 || (STAGES == 2 ? ready_i : en3);
    assign en1 = !v1 || (STAGES == 1 ? ready_i : en2);
    assign ready_o = en1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            d1 <= '0;
            m1 <= 1'b0;
            c1 <= '0;
            e1 <= 1'b0;
            n1 <= '0;
            c2 <= '0;
            e2 <= 1'b0;
            n2 <= '0;
            c3 <= '0;
            e3 <= 1'b0;
            n3 <= '0;
        end else begin
            if (en1) begin
                v1 <= valid_i;
                if (valid_i) begin
                    d1 <= data_i;
                    m1 <= mode_i;
                    c1 <= in_cnt;
                    e1 <= ~|data_i;
                    // Single-stage build finishes the shift before its only register.
                    n1 <= (STAGES == 1) ? normalise(data_i, mode_i, in_cnt) : '0;
                end
            end
            if (STAGES >= 2 && en2) begin
                v2 <= v1;
                if (v1) begin
                    c2 <= c1;
                    e2 <= e1;
                    n2 <= normalise(d1, m1, c1);
                end
            end
            if (STAGES == 3 && en3) begin
                v3 <= v2;
                if (v2) begin
                    c3 <= c2;
                    e3 <= e2;
                    n3 <= n2;
                end
            end
        end
    end

    assign valid_o = STAGES == 1 ? v1 : STAGES == 2 ? v2 : v3;
    assign cnt_o   = STAGES == 1 ? c1 : STAGES == 2 ? c2 : c3;
    assign empty_o = STAGES == 1 ? e1 : STAGES == 2 ? e2 : e3;
    assign norm_o  = STAGES == 1 ? n1 : STAGES == 2 ? n2 : n3;
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: self-checking bench for lzc_norm_pipe (32/2 main, 2/1 and 64/3 corner builds).
module tb_lzc_norm_pipe;
    typedef struct {
        logic [63:0] cnt;
        logic        empty;
        logic [63:0] norm;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        mode;
        int          cnt;
        logic        empty;
        logic [31:0] norm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_i = '0;
    logic        mode_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [4:0]  cnt_o;
    logic        empty_o;
    logic [31:0] norm_o;

    logic        rst_x = 1'b1;
    logic        valid_x = 1'b0;
    logic        mode_x = 1'b0;
    logic        ready_x = 1'b1;
    logic [1:0]  data2 = '0;
    logic [63:0] data64 = '0;
    logic        u1_ready, u1_valid, u1_cnt, u1_empty;
    logic [1:0]  u1_norm;
    logic        u3_ready, u3_valid, u3_empty;
    logic [5:0]  u3_cnt;
    logic [63:0] u3_norm;

    int   checks = 0;
    int   failures = 0;
    int   presents = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    lzc_norm_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .mode_i(mode_i), .valid_o(valid_o), .ready_i(ready_i), .cnt_o(cnt_o),
        .empty_o(empty_o), .norm_o(norm_o)
    );

    lzc_norm_pipe #(.WIDTH(2), .STAGES(1)) u1 (
        .clk_i(clk), .rst_i(rst_x), .valid_i(valid_x), .ready_o(u1_ready), .data_i(data2),
        .mode_i(mode_x), .valid_o(u1_valid), .ready_i(ready_x), .cnt_o(u1_cnt),
        .empty_o(u1_empty), .norm_o(u1_norm)
    );

    lzc_norm_pipe #(.WIDTH(64), .STAGES(3)) u3 (
        .clk_i(clk), .rst_i(rst_x), .valid_i(valid_x), .ready_o(u3_ready), .data_i(data64),
        .mode_i(mode_x), .valid_o(u3_valid), .ready_i(ready_x), .cnt_o(u3_cnt),
        .empty_o(u3_empty), .norm_o(u3_norm)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shift-until-aligned reference for a w-bit vector held in the low bits of d.
    function automatic exp_t model(input logic [63:0] d, input int w, input logic m);
        exp_t r;
        r.empty = (d == 0);
        r.cnt = 64'(w - 1);
        r.norm = '0;
        if (!r.empty) begin
            r.cnt = '0;
            r.norm = d;
            if (m) begin
                while (!r.norm[w-1]) begin
                    r.norm = r.norm << 1;
                    r.cnt = r.cnt + 1;
                end
            end else begin
                while (!r.norm[0]) begin
                    r.norm = r.norm >> 1;
                    r.cnt = r.cnt + 1;
                end
            end
        end
        return r;
    endfunction

    // Scoreboard: sampled on the falling edge, i.e. just before the edge that acts.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: valid_o=1 cnt=%0d, no result outstanding", cnt_o);
                end else begin
                    e = q.pop_front();
                    chk("out_cnt", 64'(cnt_o), e.cnt);
                    chk("out_empty", 64'(empty_o), 64'(e.empty));
                    chk("out_norm", 64'(norm_o), e.norm);
                    presents++;
                end
            end else if (valid_o && q.size() > 0) begin
                chk("hold_cnt", 64'(cnt_o), q[0].cnt);
                chk("hold_norm", 64'(norm_o), q[0].norm);
            end
            if (valid_i && ready_o) q.push_back(model({32'b0, data_i}, 32, mode_i));
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int edges;
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        data_i = v.data;
        mode_i = v.mode;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        edges = 1;
        while (!valid_o && edges < 8) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk($sformatf("vec%0d_latency", idx), 64'(edges), 64'd2);
        chk($sformatf("vec%0d_cnt", idx), 64'(cnt_o), 64'(v.cnt));
        chk($sformatf("vec%0d_empty", idx), 64'(empty_o), 64'(v.empty));
        chk($sformatf("vec%0d_norm", idx), 64'(norm_o), 64'(v.norm));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[9];
        int          k, guard, run, max_run, total, edges, p0;
        logic [31:0] sd[3];
        logic        stale1, stale3;
        vt[0] = '{32'h0000_0100, 1'b1, 23, 1'b0, 32'h8000_0000};
        vt[1] = '{32'h0000_0100, 1'b0, 8, 1'b0, 32'h0000_0001};
        vt[2] = '{32'h8000_0000, 1'b1, 0, 1'b0, 32'h8000_0000};
        vt[3] = '{32'h0000_0000, 1'b1, 31, 1'b1, 32'h0000_0000};
        vt[4] = '{32'h0000_0000, 1'b0, 31, 1'b1, 32'h0000_0000};
        vt[5] = '{32'h0000_0001, 1'b1, 31, 1'b0, 32'h8000_0000};
        vt[6] = '{32'h8000_0000, 1'b0, 31, 1'b0, 32'h0000_0001};
        vt[7] = '{32'h0000_F0A0, 1'b1, 16, 1'b0, 32'hF0A0_0000};
        vt[8] = '{32'h0000_F0A0, 1'b0, 5, 1'b0, 32'h0000_0785};

        #3;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd0);
        chk("rst_norm", 64'(norm_o), 64'd0);
        chk("x_rst_valid", 64'({u1_valid, u3_valid}), 64'd0);
        chk("x_rst_ready", 64'({u1_ready, u3_ready}), 64'd3);
        chk("x_rst_norm", u3_norm | 64'(u1_norm), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        foreach (vt[i]) run_vec(vt[i], i);

        // Back-to-back, alternating mode.
        run = 0;
        max_run = 0;
        total = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 16; c++) begin
            valid_i = (c < 8);
            if (c < 8) begin
                data_i = $urandom >> $urandom_range(0, 31);
                mode_i = c[0];
            end
            if (valid_o) begin
                run++;
                total++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            @(posedge clk);
            #1;
        end
        chk("b2b_run", 64'(max_run), 64'd8);
        chk("b2b_total", 64'(total), 64'd8);

        // Stall: 3 offered while ready_i=0 for 4 cycles.
        foreach (sd[i]) sd[i] = $urandom | 32'h1000;
        p0 = presents;
        ready_i = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            valid_i = 1'b1;
            data_i = sd[k];
            mode_i = k[0];
            @(negedge clk);
            chk($sformatf("stall_ready_%0d", c), 64'(ready_o), 64'(c < 2));
            if (ready_o) k++;
        end
        chk("stall_accepts", 64'(k), 64'd2);
        guard = 0;
        while (k < 3 && guard < 10) begin
            @(posedge clk);
            #1;
            ready_i = 1'b1;
            valid_i = 1'b1;
            data_i = sd[k];
            mode_i = k[0];
            @(negedge clk);
            if (ready_o) k++;
            guard++;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("stall_all_accepted", 64'(k), 64'd3);
        guard = 0;
        while ((q.size() != 0 || valid_o) && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("stall_presents", 64'(presents - p0), 64'd3);

        // Reset with two in flight, then first accept right after release.
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        data_i = 32'h0000_0F00;
        mode_i = 1'b1;
        @(posedge clk);
        #1;
        data_i = 32'h0000_0003;
        mode_i = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("pre_rst_valid", 64'(valid_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(valid_o), 64'd0);
        chk("mid_rst_ready", 64'(ready_o), 64'd1);
        chk("mid_rst_cnt", 64'(cnt_o), 64'd0);
        chk("mid_rst_norm", 64'(norm_o), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        valid_i = 1'b1;
        data_i = 32'h0000_0100;
        mode_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        edges = 1;
        while (!valid_o && edges < 8) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("post_rst_latency", 64'(edges), 64'd2);
        chk("post_rst_cnt", 64'(cnt_o), 64'd23);
        repeat (3) @(posedge clk);
        #1;
        chk("drained", 64'(q.size()), 64'd0);

        // WIDTH=2/STAGES=1 and WIDTH=64/STAGES=3 builds.
        @(posedge clk);
        #2;
        rst_x = 1'b0;
        ready_x = 1'b1;
        valid_x = 1'b1;
        mode_x = 1'b1;
        data2 = 2'b01;
        data64 = 64'h400;
        @(posedge clk);
        #1;
        mode_x = 1'b0;
        data2 = 2'b10;
        chk("u1_t1_valid", 64'(u1_valid), 64'd1);
        chk("u1_t1_cnt", 64'(u1_cnt), 64'd1);
        chk("u1_t1_norm", 64'(u1_norm), 64'd2);
        chk("u3_e1_valid", 64'(u3_valid), 64'd0);
        @(posedge clk);
        #1;
        mode_x = 1'b1;
        data2 = 2'b00;
        data64 = 64'h0;
        chk("u1_t2_cnt", 64'(u1_cnt), 64'd1);
        chk("u1_t2_norm", 64'(u1_norm), 64'd1);
        chk("u3_e2_valid", 64'(u3_valid), 64'd0);
        @(posedge clk);
        #1;
        valid_x = 1'b0;
        chk("u1_t3_cnt", 64'(u1_cnt), 64'd1);
        chk("u1_t3_empty", 64'(u1_empty), 64'd1);
        chk("u1_t3_norm", 64'(u1_norm), 64'd0);
        chk("u3_t1_valid", 64'(u3_valid), 64'd1);
        chk("u3_t1_cnt", 64'(u3_cnt), 64'd53);
        chk("u3_t1_norm", u3_norm, 64'h8000_0000_0000_0000);
        @(posedge clk);
        #1;
        chk("u1_idle_valid", 64'(u1_valid), 64'd0);
        chk("u3_t2_cnt", 64'(u3_cnt), 64'd10);
        chk("u3_t2_norm", u3_norm, 64'd1);
        @(posedge clk);
        #1;
        chk("u3_t3_cnt", 64'(u3_cnt), 64'd63);
        chk("u3_t3_empty", 64'(u3_empty), 64'd1);
        chk("u3_t3_norm", u3_norm, 64'd0);
        @(posedge clk);
        #1;
        chk("u3_idle_valid", 64'(u3_valid), 64'd0);

        ready_x = 1'b0;
        valid_x = 1'b1;
        data2 = 2'b11;
        data64 = 64'hFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        valid_x = 1'b0;
        chk("u1_full_ready", 64'(u1_ready), 64'd0);
        chk("u3_full_ready", 64'(u3_ready), 64'd0);
        chk("u3_full_valid", 64'(u3_valid), 64'd1);
        rst_x = 1'b1;
        #1;
        chk("x_mid_rst_valid", 64'({u1_valid, u3_valid}), 64'd0);
        chk("x_mid_rst_ready", 64'({u1_ready, u3_ready}), 64'd3);
        chk("x_mid_rst_norm", u3_norm | 64'(u1_norm), 64'd0);
        @(posedge clk);
        #2;
        rst_x = 1'b0;
        ready_x = 1'b1;
        stale1 = 1'b0;
        stale3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            stale1 |= u1_valid;
            stale3 |= u3_valid;
        end
        chk("u1_no_stale", 64'(stale1), 64'd0);
        chk("u3_no_stale", 64'(stale3), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
